// File: rtl/gate_op_scheduler.sv
// gate_op_scheduler: round-robin sharing of one AND/OR/NOT unit between NREQ requesters
//   clk, rst            clock, asynchronous active-high reset
//   req, op, a, b       per-requester request, opcode (00 AND, 01 OR, 10 NOT, 11 reserved), operands
//   gnt                 one-hot/zero combinational grant
//   rsp_valid/ready     1-deep result register handshake
//   rsp_id/op/data/err  requester index, opcode, result, reserved-opcode flag
module gate_op_scheduler #(
  parameter int NREQ = 4,
  parameter int WIDTH = 8,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [2*NREQ-1:0]      op,
  input  logic [WIDTH*NREQ-1:0]  a,
  input  logic [WIDTH*NREQ-1:0]  b,
  output logic [NREQ-1:0]        gnt,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [1:0]             rsp_op,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   rsp_err
);
  logic [IDW-1:0]   ptr_q, ptr_d, sel, rsp_id_q, rsp_id_d;
  logic             rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [1:0]       rsp_op_q, rsp_op_d, op_k;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d, a_k, b_k, res;
  logic             found, slot_free, grant;
  always_comb begin
    found = 1'b0;
    sel = '0;
    // first pending requester at or after ptr, wrapping modulo NREQ
    for (int j = 0; j < NREQ; j++)
      if (!found && req[(int'(ptr_q) + j) % NREQ]) begin
        found = 1'b1;
        sel = IDW'((int'(ptr_q) + j) % NREQ);
      end
    slot_free = !rsp_valid_q || rsp_ready;
    gnt = (found && slot_free && !rst) ? NREQ'(1) << sel : '0;
    grant = |gnt;
    op_k = op[2*sel +: 2];
    a_k = a[WIDTH*sel +: WIDTH];
    b_k = b[WIDTH*sel +: WIDTH];
    res = op_k == 2'b00 ? a_k & b_k : op_k == 2'b01 ? a_k | b_k : op_k == 2'b10 ? ~a_k : '0;
    // a grant overwrites the slot even while it is being drained
    rsp_valid_d = grant || (rsp_valid_q && !rsp_ready);
    rsp_id_d = grant ? sel : rsp_id_q;
    rsp_op_d = grant ? op_k : rsp_op_q;
    rsp_data_d = grant ? res : rsp_data_q;
    rsp_err_d = grant ? op_k == 2'b11 : rsp_err_q;
    ptr_d = grant ? (sel == IDW'(NREQ - 1) ? '0 : sel + 1'b1) : ptr_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q <= '0;
      rsp_op_q <= 2'b00;
      rsp_data_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q <= rsp_id_d;
      rsp_op_q <= rsp_op_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_id = rsp_id_q;
  assign rsp_op = rsp_op_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err = rsp_err_q;
endmodule

// File: tb/tb_gate_op_scheduler.sv
// tb_gate_op_scheduler: scoreboard bench for gate_op_scheduler with NREQ=4, WIDTH=8
module tb_gate_op_scheduler;
  typedef struct packed {
    logic [1:0] id;
    logic [1:0] op;
    logic [7:0] data;
    logic       err;
  } rsp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [7:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_id;
  logic [1:0]  rsp_op;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  rsp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic        mvalid = 1'b0;
  int          mptr = 0;
  int          wait_cnt[4];
  gate_op_scheduler #(.NREQ(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .a(a), .b(b), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_op(rsp_op), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [7:0] f(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    return o == 2'b00 ? x & y : o == 2'b01 ? x | y : o == 2'b10 ? ~x : 8'h00;
  endfunction
  function automatic int idx(input logic [3:0] g);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction
  // monitor: every presented result must match the head of the scoreboard; pop when accepted
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (q.size() == 0) chk("rsp_extra", 32'(rsp_valid), 32'd0);
      else begin
        chk("rsp", 32'({rsp_id, rsp_op, rsp_data, rsp_err}), 32'(q[0]));
        if (rsp_ready) void'(q.pop_front());
      end
    end
  end
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_fields", 32'({rsp_id, rsp_op, rsp_data, rsp_err}), 32'd0);
    q.delete();
    mvalid = 1'b0;
    mptr = 0;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  // drive one cycle of inputs, check grant/valid, and queue the expected result of a grant
  task automatic cycle(input logic [3:0] r, input logic [7:0] o, input logic [31:0] av,
                       input logic [31:0] bv, input logic rdy, input logic [3:0] eg,
                       input logic [7:0] ed, input logic ee);
    int k;
    req = r; op = o; a = av; b = bv; rsp_ready = rdy;
    @(negedge clk);
    chk("gnt", 32'(gnt), 32'(eg));
    chk("valid", 32'(rsp_valid), 32'(mvalid));
    if (eg != 4'd0) begin
      k = idx(eg);
      q.push_back('{id: 2'(k), op: o[2*k +: 2], data: ed, err: ee});
      mptr = (k + 1) % 4;
    end
    mvalid = (eg != 4'd0) || (mvalid && !rdy);
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [3:0]  pend, eg;
    logic [7:0]  ro, ed;
    logic [31:0] ra, rb;
    logic        rdy, ee;
    int          k;
    #2;
    do_reset();
    // one requester, each opcode, a=F0 b=3C
    cycle(4'b0001, 8'h00, 32'hF0, 32'h3C, 1'b1, 4'b0001, 8'h30, 1'b0);
    cycle(4'b0001, 8'h01, 32'hF0, 32'h3C, 1'b1, 4'b0001, 8'hFC, 1'b0);
    cycle(4'b0001, 8'h02, 32'hF0, 32'h3C, 1'b1, 4'b0001, 8'h0F, 1'b0);
    cycle(4'b0001, 8'h03, 32'hF0, 32'h3C, 1'b1, 4'b0001, 8'h00, 1'b1);
    // hold the result, then reset with every requester pending
    cycle(4'b0000, 8'h03, 32'hF0, 32'h3C, 1'b0, 4'b0000, 8'h00, 1'b0);
    req = 4'b1111;
    do_reset();
    // full rotation from index 0; r0 AND, r1 OR, r2 NOT, r3 reserved
    cycle(4'b1111, 8'hE4, 32'h44332211, 32'h88776655, 1'b1, 4'b0001, 8'h11, 1'b0);
    cycle(4'b1111, 8'hE4, 32'h44332211, 32'h88776655, 1'b1, 4'b0010, 8'h66, 1'b0);
    cycle(4'b1111, 8'hE4, 32'h44332211, 32'h88776655, 1'b1, 4'b0100, 8'hCC, 1'b0);
    cycle(4'b1111, 8'hE4, 32'h44332211, 32'h88776655, 1'b1, 4'b1000, 8'h00, 1'b1);
    cycle(4'b1111, 8'hE4, 32'h44332211, 32'h88776655, 1'b1, 4'b0001, 8'h11, 1'b0);
    // grant to 2 leaves ptr=3, then 0101 wraps to 0 before 2
    cycle(4'b0100, 8'hE4, 32'h44332211, 32'h88776655, 1'b1, 4'b0100, 8'hCC, 1'b0);
    cycle(4'b0101, 8'hE4, 32'h44332211, 32'h88776655, 1'b1, 4'b0001, 8'h11, 1'b0);
    cycle(4'b0101, 8'hE4, 32'h44332211, 32'h88776655, 1'b1, 4'b0100, 8'hCC, 1'b0);
    // backpressure for five cycles, then drain and grant together
    repeat (5) cycle(4'b0011, 8'hE4, 32'h44332211, 32'h88776655, 1'b0, 4'b0000, 8'h00, 1'b0);
    cycle(4'b0011, 8'hE4, 32'h44332211, 32'h88776655, 1'b1, 4'b0001, 8'h11, 1'b0);
    cycle(4'b0010, 8'hE4, 32'h44332211, 32'h88776655, 1'b1, 4'b0010, 8'h66, 1'b0);
    cycle(4'b0000, 8'hE4, 32'h44332211, 32'h88776655, 1'b1, 4'b0000, 8'h00, 1'b0);
    chk("drained", 32'(q.size()), 32'd0);
    // random traffic; requests stay stable until granted
    pend = '0; ro = '0; ra = '0; rb = '0;
    for (int n = 0; n < 10000; n++) begin
      rdy = $urandom_range(0, 3) != 0;
      for (int i = 0; i < 4; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          ro[2*i +: 2] = 2'($urandom_range(0, 3));
          ra[8*i +: 8] = 8'($urandom);
          rb[8*i +: 8] = 8'($urandom);
        end
      eg = '0;
      if (!mvalid || rdy)
        for (int j = 0; j < 4; j++)
          if (eg == 4'd0 && pend[(mptr + j) % 4]) eg[(mptr + j) % 4] = 1'b1;
      k = idx(eg);
      ed = f(ro[2*k +: 2], ra[8*k +: 8], rb[8*k +: 8]);
      ee = ro[2*k +: 2] == 2'b11;
      for (int i = 0; i < 4; i++)
        if (pend[i] && eg != 4'd0) begin
          if (eg[i]) begin
            chk("max_wait", 32'(wait_cnt[i] < 4), 32'd1);
            wait_cnt[i] = 0;
          end else wait_cnt[i]++;
        end
      cycle(pend, ro, ra, rb, rdy, eg, ed, ee);
      pend &= ~eg;
    end
    repeat (2) cycle(4'b0000, ro, ra, rb, 1'b1, 4'b0000, 8'h00, 1'b0);
    chk("final_drain", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
